// File: rtl/parent_call_agent.sv
// Call/return agent between a multithreaded core and its child command/return FIFOs.
// Tracks outstanding return-calls per thread and supports a drain handshake.
module parent_call_agent #(
  parameter  int THREAD     = 16,
  parameter  int CHILD      = 256,
  parameter  int ARG_W      = 32,
  parameter  int ARG_NUM    = 4,
  parameter  int MAX_OUT    = 15,
  localparam int LOG_THREAD = (THREAD == 1) ? 1 : $clog2(THREAD),
  localparam int LOG_CHILD  = (CHILD == 1) ? 1 : $clog2(CHILD),
  localparam int CMD_DW     = ARG_W*ARG_NUM + LOG_THREAD + LOG_CHILD + 1 + 32,
  localparam int RET_DW     = 32 + LOG_THREAD
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        core_call_vld_i,
  output logic                        core_call_rdy_o,
  input  logic [LOG_CHILD-1:0]        core_call_child_i,
  input  logic [LOG_THREAD-1:0]       core_call_thread_i,
  input  logic                        core_call_retreq_i,
  input  logic [31:0]                 core_call_pc_i,
  input  logic [ARG_NUM*ARG_W-1:0]    core_call_args_i,
  output logic [CMD_DW-1:0]           cmdfifo_din_o,
  output logic                        cmdfifo_write_o,
  input  logic                        cmdfifo_full_n_i,
  input  logic                        retfifo_empty_n_i,
  output logic                        retfifo_pop_o,
  input  logic [RET_DW+LOG_CHILD-1:0] retfifo_dout_i,
  output logic                        core_ret_vld_o,
  input  logic                        core_ret_rdy_i,
  output logic [31:0]                 core_ret_data_o,
  output logic [LOG_THREAD-1:0]       core_ret_thread_o,
  output logic [LOG_CHILD-1:0]        core_ret_child_o,
  output logic [THREAD-1:0]           thread_busy_o,
  input  logic                        drain_i,
  output logic                        drain_done_o,
  output logic                        err_underflow_o
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int THR_LSB = 33 + LOG_CHILD;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_slot_vld;
  logic [CMD_DW-1:0]     r_slot;
  logic                  r_ret_vld;
  logic [31:0]           r_ret_data;
  logic [LOG_THREAD-1:0] r_ret_thr;
  logic [LOG_CHILD-1:0]  r_ret_chd;
  logic [CNT_W-1:0]      r_cnt [THREAD];
  logic [CNT_W-1:0]      w_cnt_nxt [THREAD];
  logic                  r_err;
  logic                  r_done;

  logic                  w_wr;
  logic                  w_ret_hs;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_room;
  logic                  w_uf;
  logic                  w_idle;
  logic                  w_done_set;
  logic                  w_slot_rr;
  logic [LOG_THREAD-1:0] w_slot_thr;
  logic [THREAD-1:0]     w_inc;
  logic [THREAD-1:0]     w_dec;
  logic [THREAD-1:0]     w_busy;

  assign w_slot_rr  = r_slot[32];
  assign w_slot_thr = r_slot[THR_LSB +: LOG_THREAD];
  assign w_wr       = r_slot_vld & cmdfifo_full_n_i;
  assign w_ret_hs   = r_ret_vld & core_ret_rdy_i;
  // Gated by rstn so no pop can escape while the return register is held in reset.
  assign w_pop      = rstn & retfifo_empty_n_i & (~r_ret_vld | core_ret_rdy_i);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_wr & w_slot_rr) w_inc[w_slot_thr] = 1'b1;
    if (w_ret_hs)         w_dec[r_ret_thr]  = 1'b1;
  end

  always_comb begin
    w_uf = 1'b0;
    for (int t = 0; t < THREAD; t++) begin
      w_cnt_nxt[t] = r_cnt[t];
      w_busy[t]    = |r_cnt[t];
      if (w_dec[t] && r_cnt[t] == '0) w_uf = 1'b1;
      if (w_inc[t] && !w_dec[t])
        w_cnt_nxt[t] = r_cnt[t] + CNT_W'(1);
      else if (w_dec[t] && !w_inc[t] && r_cnt[t] != '0)
        w_cnt_nxt[t] = r_cnt[t] - CNT_W'(1);
    end
  end

  assign w_room   = w_cnt_nxt[core_call_thread_i] < CNT_W'(MAX_OUT);
  assign core_call_rdy_o = rstn & (r_state == S_RUN)
                         & (~r_slot_vld | w_wr)
                         & (~core_call_retreq_i | w_room);
  assign w_accept = core_call_vld_i & core_call_rdy_o;
  assign w_idle   = ~r_slot_vld & ~|w_busy & ~r_ret_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    unique case (r_state)
      S_RUN:   if (drain_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_idle) begin
        w_state_nxt = S_DONE;
        w_done_set  = 1'b1;
      end
      S_DONE:  if (!drain_i) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_RUN;
      r_slot_vld <= 1'b0;
      r_slot     <= '0;
      r_ret_vld  <= 1'b0;
      r_ret_data <= '0;
      r_ret_thr  <= '0;
      r_ret_chd  <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      for (int t = 0; t < THREAD; t++) r_cnt[t] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_set;
      if (w_uf) r_err <= 1'b1;
      for (int t = 0; t < THREAD; t++) r_cnt[t] <= w_cnt_nxt[t];
      if (w_accept) begin
        r_slot_vld <= 1'b1;
        r_slot     <= {core_call_args_i, core_call_thread_i,
                       core_call_child_i, core_call_retreq_i,
                       core_call_pc_i};
      end else if (w_wr) begin
        r_slot_vld <= 1'b0;
      end
      if (w_pop) begin
        r_ret_vld  <= 1'b1;
        r_ret_data <= retfifo_dout_i[31:0];
        r_ret_thr  <= retfifo_dout_i[32 +: LOG_THREAD];
        r_ret_chd  <= retfifo_dout_i[RET_DW +: LOG_CHILD];
      end else if (w_ret_hs) begin
        r_ret_vld  <= 1'b0;
      end
    end
  end

  assign cmdfifo_din_o     = r_slot;
  assign cmdfifo_write_o   = w_wr;
  assign retfifo_pop_o     = w_pop;
  assign core_ret_vld_o    = r_ret_vld;
  assign core_ret_data_o   = r_ret_data;
  assign core_ret_thread_o = r_ret_thr;
  assign core_ret_child_o  = r_ret_chd;
  assign thread_busy_o     = w_busy;
  assign drain_done_o      = r_done;
  assign err_underflow_o   = r_err;

endmodule

// File: tb/tb_parent_call_agent.sv
// Bench for parent_call_agent: vector table, directed corner sequences,
// then random traffic against a queue-based model.
module tb_parent_call_agent;
  localparam int CDW = 173;
  localparam int RDW = 44;

  logic           clk = 1'b0;
  logic           rstn;
  logic           call_vld, call_rdy, call_rr;
  logic [7:0]     call_chd;
  logic [3:0]     call_thr;
  logic [31:0]    call_pc;
  logic [127:0]   call_args;
  logic [CDW-1:0] din;
  logic           wr, full_n, empty_n, pop;
  logic [RDW-1:0] dout;
  logic           ret_vld, ret_rdy;
  logic [31:0]    ret_data;
  logic [3:0]     ret_thr;
  logic [7:0]     ret_chd;
  logic [15:0]    busy;
  logic           drain, drain_done, err;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (drain_done) n_pulse++;

  parent_call_agent dut (
    .clk(clk), .rstn(rstn),
    .core_call_vld_i(call_vld), .core_call_rdy_o(call_rdy),
    .core_call_child_i(call_chd), .core_call_thread_i(call_thr),
    .core_call_retreq_i(call_rr), .core_call_pc_i(call_pc),
    .core_call_args_i(call_args),
    .cmdfifo_din_o(din), .cmdfifo_write_o(wr),
    .cmdfifo_full_n_i(full_n),
    .retfifo_empty_n_i(empty_n), .retfifo_pop_o(pop),
    .retfifo_dout_i(dout),
    .core_ret_vld_o(ret_vld), .core_ret_rdy_i(ret_rdy),
    .core_ret_data_o(ret_data), .core_ret_thread_o(ret_thr),
    .core_ret_child_o(ret_chd),
    .thread_busy_o(busy), .drain_i(drain),
    .drain_done_o(drain_done), .err_underflow_o(err)
  );

  function automatic logic [CDW-1:0] pack(
    input logic [7:0] c, input logic [3:0] t, input logic r,
    input logic [31:0] pc, input logic [127:0] a);
    return {a, t, c, r, pc};
  endfunction

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_call(input logic [7:0] c, input logic [3:0] t,
                          input logic r, input logic [31:0] pc,
                          input logic [127:0] a);
    call_vld = 1'b1; call_chd = c; call_thr = t;
    call_rr = r; call_pc = pc; call_args = a;
  endtask

  task automatic do_call(input logic [7:0] c, input logic [3:0] t,
                         input logic r, input logic [31:0] pc);
    int g = 0;
    set_call(c, t, r, pc, {4{pc}});
    #1;
    while (!call_rdy && g < 50) begin tick(); g++; end
    chk("call_accept", call_rdy, 1'b1);
    tick();
    call_vld = 1'b0;
  endtask

  task automatic do_returns(input logic [3:0] t, input int n);
    int pops = 0;
    int g = 0;
    dout = {8'h11, t, 32'hC0DE0000 | 32'(t)};
    empty_n = 1'b1;
    ret_rdy = 1'b1;
    while (pops < n && g < 100) begin
      #1;
      if (pop) pops++;
      @(posedge clk);
      #1;
      g++;
    end
    empty_n = 1'b0;
    g = 0;
    while (ret_vld && g < 20) begin tick(); g++; end
    chk("returns_done", {(pops == n), ret_vld}, 2'b10);
  endtask

  typedef struct {
    logic [7:0]   c;
    logic [3:0]   t;
    logic         r;
    logic [31:0]  pc;
    logic [127:0] a;
    logic [15:0]  busy;
  } vec_t;

  typedef struct { logic [CDW-1:0] cmd; logic [3:0] t; logic r; } cq_t;
  typedef struct { logic [31:0] d; logic [3:0] t; logic [7:0] c; } rq_t;

  vec_t tv[5];
  cq_t  cq[$];
  rq_t  rq[$];
  int   m_cnt[16];
  int   infl[16];

  initial begin
    tv[0] = '{8'd5,  4'd3, 1'b1, 32'h100,
              {32'h4, 32'h3, 32'h2, 32'h1}, 16'h0008};
    tv[1] = '{8'd0,  4'd0, 1'b0, 32'hFFFFFFFF, {128{1'b1}}, 16'h0008};
    tv[2] = '{8'hFF, 4'hF, 1'b0, 32'h0, 128'h0, 16'h0008};
    tv[3] = '{8'h3C, 4'd3, 1'b1, 32'h12345678,
              128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0001, 16'h0008};
    tv[4] = '{8'd1,  4'd1, 1'b1, 32'h8000_0004,
              128'h1, 16'h000A};

    rstn = 1'b0; call_vld = 1'b0; call_chd = '0; call_thr = '0;
    call_rr = 1'b0; call_pc = '0; call_args = '0;
    full_n = 1'b1; empty_n = 1'b1; dout = '0; ret_rdy = 1'b1;
    drain = 1'b0;

    // reset state, with a return FIFO that looks non-empty
    tick(); tick();
    chk("rst_pop", pop, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_ret_vld", ret_vld, 1'b0);
    chk("rst_done", drain_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 16'h0);
    empty_n = 1'b0;
    rstn = 1'b1;
    tick();
    chk("idle_rdy", call_rdy, 1'b1);

    // vector table: single calls, packing and busy tracking
    for (int i = 0; i < 5; i++) begin
      set_call(tv[i].c, tv[i].t, tv[i].r, tv[i].pc, tv[i].a);
      #1;
      chk("tv_rdy", call_rdy, 1'b1);
      tick();
      call_vld = 1'b0;
      #1;
      chk("tv_wr", wr, 1'b1);
      chk("tv_din", din,
          pack(tv[i].c, tv[i].t, tv[i].r, tv[i].pc, tv[i].a));
      tick();
      chk("tv_wr_off", wr, 1'b0);
      chk("tv_busy", busy, tv[i].busy);
    end

    do_returns(4'd1, 1);
    do_returns(4'd3, 1);
    chk("pre26_busy", busy, 16'h0008);

    // held return entry: single pop, outputs stable while stalled
    dout = {8'd5, 4'd3, 32'hDEAD};
    empty_n = 1'b1;
    ret_rdy = 1'b0;
    #1;
    chk("s26_pop", pop, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s26_vld", ret_vld, 1'b1);
      chk("s26_out", {ret_chd, ret_thr, ret_data}, {8'd5, 4'd3, 32'hDEAD});
      chk("s26_nopop", pop, 1'b0);
      chk("s26_busy", busy[3], 1'b1);
    end
    empty_n = 1'b0;
    ret_rdy = 1'b1;
    tick();
    chk("s26_vld_off", ret_vld, 1'b0);
    chk("s26_dec", busy, 16'h0);

    // command FIFO full for 4 cycles with the slot loaded
    full_n = 1'b0;
    set_call(8'h21, 4'd4, 1'b0, 32'hAAAA0000, 128'hA);
    #1;
    chk("s24_first_rdy", call_rdy, 1'b1);
    tick();
    set_call(8'h22, 4'd4, 1'b0, 32'hBBBB0000, 128'hB);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("s24_nowr", wr, 1'b0);
      chk("s24_stall", call_rdy, 1'b0);
      chk("s24_hold", din, pack(8'h21, 4'd4, 1'b0, 32'hAAAA0000, 128'hA));
      tick();
    end
    full_n = 1'b1;
    #1;
    chk("s24_wr", wr, 1'b1);
    chk("s24_din", din, pack(8'h21, 4'd4, 1'b0, 32'hAAAA0000, 128'hA));
    chk("s24_rdy", call_rdy, 1'b1);
    tick();
    call_vld = 1'b0;
    #1;
    chk("s24_wr2", wr, 1'b1);
    chk("s24_din2", din, pack(8'h22, 4'd4, 1'b0, 32'hBBBB0000, 128'hB));
    tick();
    chk("s24_wr_off", wr, 1'b0);

    // outstanding limit on thread 0
    set_call(8'h07, 4'd0, 1'b1, 32'h40, 128'h0);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("s25_acc", call_rdy, 1'b1);
      tick();
    end
    #1;
    chk("s25_stall", call_rdy, 1'b0);
    tick();
    chk("s25_stall2", call_rdy, 1'b0);
    chk("s25_busy", busy, 16'h0001);
    dout = {8'h07, 4'd0, 32'h1};
    empty_n = 1'b1;
    ret_rdy = 1'b1;
    #1;
    chk("s25_pop", pop, 1'b1);
    chk("s25_stall3", call_rdy, 1'b0);
    tick();
    empty_n = 1'b0;
    #1;
    chk("s25_ret_vld", ret_vld, 1'b1);
    chk("s25_release", call_rdy, 1'b1);
    tick();
    call_vld = 1'b0;
    #1;
    chk("s25_wr16", wr, 1'b1);
    tick();
    do_returns(4'd0, 15);
    chk("s25_clean", busy, 16'h0);

    // drain with two outstanding calls
    do_call(8'h20, 4'd2, 1'b1, 32'h200);
    do_call(8'h20, 4'd2, 1'b1, 32'h204);
    tick();
    chk("s28_busy", busy, 16'h0004);
    n_pulse = 0;
    drain = 1'b1;
    tick();
    set_call(8'h30, 4'd5, 1'b0, 32'h300, 128'h0);
    #1;
    chk("s28_block", call_rdy, 1'b0);
    do_returns(4'd2, 1);
    chk("s28_nodone", n_pulse, 0);
    do_returns(4'd2, 1);
    repeat (5) tick();
    chk("s28_pulse", n_pulse, 1);
    chk("s28_done_low", drain_done, 1'b0);
    chk("s28_block_done", call_rdy, 1'b0);
    drain = 1'b0;
    tick();
    chk("s28_resume", call_rdy, 1'b1);
    tick();
    call_vld = 1'b0;
    tick();
    chk("s28_wr_off", wr, 1'b0);

    // random traffic against the queue model
    for (int t = 0; t < 16; t++) begin m_cnt[t] = 0; infl[t] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_wr, e_hs, e_rdy, e_pop, inc, dec;
      logic [15:0] m_busy;
      int          a, cand;
      cq_t         ce;
      rq_t         re;
      call_vld = ($urandom % 4) != 0;
      call_thr = 4'($urandom % 4);
      call_rr  = 1'($urandom % 2);
      call_chd = 8'($urandom);
      call_pc  = $urandom;
      call_args = {$urandom, $urandom, $urandom, $urandom};
      full_n  = ($urandom % 4) != 0;
      ret_rdy = ($urandom % 3) != 0;
      empty_n = 1'b0;
      cand = $urandom % 4;
      re = '{$urandom, 4'(cand), 8'($urandom)};
      if (m_cnt[cand] - infl[cand] > 0 && ($urandom % 2) == 1) empty_n = 1'b1;
      dout = {re.c, re.t, re.d};
      #1;
      e_wr = cq.size() > 0 && full_n;
      e_hs = rq.size() > 0 && ret_rdy;
      a = m_cnt[call_thr];
      inc = e_wr && cq[0].r && cq[0].t == call_thr;
      dec = e_hs && rq[0].t == call_thr;
      if (inc && !dec) a++;
      else if (dec && !inc && a > 0) a--;
      e_rdy = (cq.size() == 0 || e_wr) && (!call_rr || a < 15);
      e_pop = empty_n && (rq.size() == 0 || ret_rdy);
      for (int t = 0; t < 16; t++) m_busy[t] = m_cnt[t] != 0;
      chk("rnd_rdy", call_rdy, e_rdy);
      chk("rnd_wr", wr, e_wr);
      chk("rnd_pop", pop, e_pop);
      chk("rnd_ret_vld", ret_vld, rq.size() > 0);
      chk("rnd_busy", busy, m_busy);
      if (e_wr) chk("rnd_din", din, cq[0].cmd);
      if (rq.size() > 0)
        chk("rnd_ret", {ret_chd, ret_thr, ret_data},
            {rq[0].c, rq[0].t, rq[0].d});
      if (e_wr) begin
        ce = cq.pop_front();
        if (ce.r) m_cnt[ce.t]++;
      end
      if (e_hs) begin
        rq_t h;
        h = rq.pop_front();
        m_cnt[h.t]--;
        infl[h.t]--;
      end
      if (call_vld && e_rdy)
        cq.push_back('{pack(call_chd, call_thr, call_rr, call_pc, call_args),
                       call_thr, call_rr});
      if (e_pop) begin
        rq.push_back(re);
        infl[cand]++;
      end
      tick();
    end
    call_vld = 1'b0; empty_n = 1'b0; ret_rdy = 1'b1; full_n = 1'b1;
    repeat (4) tick();

    // return for a thread with nothing outstanding
    chk("s27_pre", err, 1'b0);
    do_returns(4'd9, 1);
    chk("s27_err", err, 1'b1);
    chk("s27_cnt", busy[9], 1'b0);
    repeat (3) tick();
    chk("s27_sticky", err, 1'b1);

    // reset mid-transaction
    full_n = 1'b0;
    do_call(8'h44, 4'd6, 1'b1, 32'h600);
    dout = {8'h44, 4'd6, 32'h77};
    empty_n = 1'b1;
    ret_rdy = 1'b0;
    tick();
    full_n = 1'b1;
    rstn = 1'b0;
    #1;
    chk("r22_wr", wr, 1'b0);
    chk("r22_pop", pop, 1'b0);
    chk("r22_ret_vld", ret_vld, 1'b0);
    chk("r22_err", err, 1'b0);
    tick();
    empty_n = 1'b0;
    rstn = 1'b1;
    tick();
    chk("r22_slot_gone", wr, 1'b0);
    chk("r22_ret_gone", ret_vld, 1'b0);
    chk("r22_busy", busy, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
